pwm_multi_channel: RTL and testbench

- Multi-channel PWM timer, successor to the single-channel generator.
- One runtime-programmable prescaler and one shared time-base counter drive CH_N compare channels.
- Supports edge-aligned and center-aligned counting, per-channel polarity and complementary outputs with programmable dead-time.
- All settings are shadow-buffered and take effect only at the period boundary (update event). Used for beeper, LED and motor-drive outputs.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_deadtime.sv | 64 ++++++
 rtl/pwm_multi_channel.sv | 152 +++++++++++++++
 tb/tb_pwm_multi_channel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM timer.
package pwm_pkg;

  localparam logic ALIGN_EDGE   = 1'b0;
  localparam logic ALIGN_CENTER = 1'b1;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CH_N_DEF  = 4;
  localparam int unsigned PSC_W_DEF = 16;
  localparam int unsigned DT_W_DEF  = 8;

  // Upper bounds for the generic slice helper.
  localparam int unsigned MAX_W  = 32;
  localparam int unsigned MAX_CH = 16;
  localparam int unsigned BUS_W  = MAX_W * MAX_CH;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Returns channel idx of a packed per-channel bus; caller truncates to its width.
  function automatic logic [MAX_W-1:0] pulse_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned       idx,
                                                   input int unsigned       w);
    return MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output pair with programmable dead-time inserted on each edge of act_i.
module pwm_deadtime #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            act_i,
  input  logic [DT_W-1:0] dt_i,
  output logic            out_o,
  output logic            out_n_o
);

  logic            act_prev_q, act_prev_d;
  logic            out_q, out_d;
  logic            out_n_q, out_n_d;
  logic [DT_W-1:0] dly_q, dly_d;

  always_comb begin
    act_prev_d = act_i;
    out_d      = out_q;
    out_n_d    = out_n_q;
    dly_d      = dly_q;
    if (!en_i) begin
      // Preload the delay so a constant-low act still releases out_n after dead-time.
      act_prev_d = 1'b0;
      out_d      = 1'b0;
      out_n_d    = 1'b0;
      dly_d      = dt_i;
    end else if (dt_i == '0) begin
      out_d   = act_i;
      out_n_d = ~act_i;
      dly_d   = '0;
    end else if (act_i != act_prev_q) begin
      out_d   = 1'b0;
      out_n_d = 1'b0;
      dly_d   = dt_i;
    end else if (dly_q == DT_W'(1)) begin
      out_d   = act_i;
      out_n_d = ~act_i;
      dly_d   = '0;
    end else if (dly_q != '0) begin
      dly_d = dly_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_prev_q <= 1'b0;
      out_q      <= 1'b0;
      out_n_q    <= 1'b0;
      dly_q      <= '0;
    end else begin
      act_prev_q <= act_prev_d;
      out_q      <= out_d;
      out_n_q    <= out_n_d;
      dly_q      <= dly_d;
    end
  end

  assign out_o   = out_q;
  assign out_n_o = out_n_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM timer: prescaler, shared edge/center time base, shadowed compare
// channels and per-channel dead-time complementary outputs.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned CH_N  = CH_N_DEF,
  parameter int unsigned PSC_W = PSC_W_DEF,
  parameter int unsigned DT_W  = DT_W_DEF
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PSC_W-1:0]      psc,
  input  logic [CNT_W-1:0]      period,
  input  logic                  align,
  input  logic [CH_N*CNT_W-1:0] pulse,
  input  logic [CH_N-1:0]       pol,
  input  logic [DT_W-1:0]       dt,
  output logic [CH_N-1:0]       pwm_out,
  output logic [CH_N-1:0]       pwm_out_n,
  output logic                  upd_evt,
  output logic [CNT_W-1:0]      cnt_val
);

  logic [PSC_W-1:0]      psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dir_e                  dir_q, dir_d;
  logic [PSC_W-1:0]      psc_sh_q, psc_sh_d;
  logic [CNT_W-1:0]      period_sh_q, period_sh_d;
  logic                  align_sh_q, align_sh_d;
  logic [CH_N*CNT_W-1:0] pulse_sh_q, pulse_sh_d;
  logic [CH_N-1:0]       pol_sh_q, pol_sh_d;
  logic [DT_W-1:0]       dt_sh_q, dt_sh_d;
  logic                  upd_evt_q, upd_evt_d;
  logic [CH_N-1:0]       act_q, act_d;

  logic                  tick;
  logic                  upd;
  logic                  load_sh;
  logic [BUS_W-1:0]      pulse_bus;
  logic [CNT_W-1:0]      pulse_ch [CH_N];

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    upd       = 1'b0;
    tick      = (psc_cnt_q == psc_sh_q);
    if (!en) begin
      psc_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = DirUp;
    end else if (!tick) begin
      psc_cnt_d = psc_cnt_q + 1'b1;
    end else begin
      psc_cnt_d = '0;
      if (period_sh_q == '0) begin
        upd   = 1'b1;
        cnt_d = '0;
        dir_d = DirUp;
      end else if (align_sh_q == ALIGN_EDGE) begin
        dir_d = DirUp;
        // Compare before increment so P = all-ones wraps explicitly.
        if (cnt_q == period_sh_q) begin
          upd   = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dir_q == DirUp) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == period_sh_q) dir_d = DirDown;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          upd   = 1'b1;
          dir_d = DirUp;
        end
      end
    end
  end

  // Shadows are transparent while disabled and otherwise refresh only on update events.
  always_comb begin
    load_sh     = !en || upd;
    psc_sh_d    = load_sh ? psc    : psc_sh_q;
    period_sh_d = load_sh ? period : period_sh_q;
    align_sh_d  = load_sh ? align  : align_sh_q;
    pulse_sh_d  = load_sh ? pulse  : pulse_sh_q;
    pol_sh_d    = load_sh ? pol    : pol_sh_q;
    dt_sh_d     = load_sh ? dt     : dt_sh_q;
    upd_evt_d   = upd;
  end

  assign pulse_bus = BUS_W'(pulse_sh_q);

  always_comb begin
    act_d = '0;
    for (int i = 0; i < CH_N; i++) begin
      act_d[i] = en & ((cnt_q < pulse_ch[i]) ^ pol_sh_q[i]);
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      psc_cnt_q   <= '0;
      cnt_q       <= '0;
      dir_q       <= DirUp;
      psc_sh_q    <= '0;
      period_sh_q <= '0;
      align_sh_q  <= ALIGN_EDGE;
      pulse_sh_q  <= '0;
      pol_sh_q    <= '0;
      dt_sh_q     <= '0;
      upd_evt_q   <= 1'b0;
      act_q       <= '0;
    end else begin
      psc_cnt_q   <= psc_cnt_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      psc_sh_q    <= psc_sh_d;
      period_sh_q <= period_sh_d;
      align_sh_q  <= align_sh_d;
      pulse_sh_q  <= pulse_sh_d;
      pol_sh_q    <= pol_sh_d;
      dt_sh_q     <= dt_sh_d;
      upd_evt_q   <= upd_evt_d;
      act_q       <= act_d;
    end
  end

  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    assign pulse_ch[i] = CNT_W'(pulse_slice(pulse_bus, i, CNT_W));

    pwm_deadtime #(
      .DT_W (DT_W)
    ) u_deadtime (
      .clk_i   (sclk),
      .rst_i   (rst),
      .en_i    (en),
      .act_i   (act_q[i]),
      .dt_i    (dt_sh_q),
      .out_o   (pwm_out[i]),
      .out_n_o (pwm_out_n[i])
    );
  end

  assign upd_evt = upd_evt_q;
  assign cnt_val = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench: each update event closes a measurement window that is compared
// against the expected period length and per-channel high counts.
module tb_pwm_multi_channel;

  localparam int CNT_W = 16;
  localparam int CH_N  = 4;
  localparam int PSC_W = 16;
  localparam int DT_W  = 8;

  logic                  sclk;
  logic                  rst;
  logic                  en;
  logic [PSC_W-1:0]      psc;
  logic [CNT_W-1:0]      period;
  logic                  align;
  logic [CH_N*CNT_W-1:0] pulse;
  logic [CH_N-1:0]       pol;
  logic [DT_W-1:0]       dt;
  logic [CH_N-1:0]       pwm_out;
  logic [CH_N-1:0]       pwm_out_n;
  logic                  upd_evt;
  logic [CNT_W-1:0]      cnt_val;

  typedef struct packed {
    logic             chk;
    logic [15:0]      len;
    logic [3:0][15:0] hi;
    logic [3:0][15:0] hin;
  } rec_t;

  rec_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rec    = 0;

  pwm_multi_channel #(
    .CNT_W (CNT_W),
    .CH_N  (CH_N),
    .PSC_W (PSC_W),
    .DT_W  (DT_W)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .en        (en),
    .psc       (psc),
    .period    (period),
    .align     (align),
    .pulse     (pulse),
    .pol       (pol),
    .dt        (dt),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n),
    .upd_evt   (upd_evt),
    .cnt_val   (cnt_val)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction

  task automatic push(input logic chk, input int len, input logic [3:0][15:0] hi,
                      input logic [3:0][15:0] hin);
    rec_t r;
    r.chk = chk;
    r.len = 16'(len);
    r.hi  = hi;
    r.hin = hin;
    sb_q.push_back(r);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 0, '0, '0);
  endtask

  task automatic setup(input logic al, input int ps, input int p, input logic [63:0] pu,
                       input logic [3:0] po, input int d);
    en     = 1'b0;
    align  = al;
    psc    = PSC_W'(ps);
    period = CNT_W'(p);
    pulse  = pu;
    pol    = po;
    dt     = DT_W'(d);
    repeat (3) @(negedge sclk);
  endtask

  // k update events of l sclk each; stop half a period after the last one.
  task automatic run(input int k, input int l);
    en = 1'b1;
    repeat (k * l + l / 2) @(negedge sclk);
    en = 1'b0;
  endtask

  initial begin : monitor
    rec_t r;
    int   len;
    int   both;
    int   hi  [CH_N];
    int   hin [CH_N];
    len  = 0;
    both = 0;
    for (int i = 0; i < CH_N; i++) begin
      hi[i]  = 0;
      hin[i] = 0;
    end
    forever begin
      @(negedge sclk);
      if (upd_evt === 1'b1) begin
        check("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          r = sb_q.pop_front();
          n_rec++;
          if (r.chk) begin
            check($sformatf("rec%0d_len", n_rec), len, int'(r.len));
            for (int i = 0; i < CH_N; i++) begin
              check($sformatf("rec%0d_hi_ch%0d", n_rec, i), hi[i], int'(r.hi[i]));
              check($sformatf("rec%0d_hin_ch%0d", n_rec, i), hin[i], int'(r.hin[i]));
            end
            check($sformatf("rec%0d_overlap", n_rec), both, 0);
          end
        end
        len  = 0;
        both = 0;
        for (int i = 0; i < CH_N; i++) begin
          hi[i]  = 0;
          hin[i] = 0;
        end
      end
      len++;
      for (int i = 0; i < CH_N; i++) begin
        hi[i]  += int'(pwm_out[i]);
        hin[i] += int'(pwm_out_n[i]);
      end
      both += int'(|(pwm_out & pwm_out_n));
    end
  end

  initial begin : stimulus
    int lat;
    rst    = 1'b1;
    en     = 1'b0;
    align  = 1'b0;
    psc    = '0;
    period = '0;
    pulse  = '0;
    pol    = '0;
    dt     = '0;
    repeat (2) @(negedge sclk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_out_n", int'(pwm_out_n), 0);
    check("rst_upd_evt", int'(upd_evt), 0);
    check("rst_cnt_val", int'(cnt_val), 0);
    rst = 1'b0;

    // Edge, P=9: ch0 3/7, ch1 pulse 0, ch2 pulse>P, ch3 5/5.
    setup(1'b0, 0, 9, {16'd5, 16'd10, 16'd0, 16'd3}, 4'h0, 0);
    skip(2);
    for (int i = 0; i < 3; i++)
      push(1'b1, 10, {16'd5, 16'd10, 16'd0, 16'd3}, {16'd5, 16'd0, 16'd10, 16'd7});
    run(5, 10);

    // Center, P=8, psc=1: 16 ticks x 2. cnt<4 holds for 0,1,2,3 up and 3,2,1 down.
    setup(1'b1, 1, 8, {16'd8, 16'd9, 16'd4, 16'd0}, 4'h0, 0);
    skip(2);
    for (int i = 0; i < 2; i++)
      push(1'b1, 32, {16'd30, 16'd32, 16'd14, 16'd0}, {16'd2, 16'd0, 16'd18, 16'd32});
    run(4, 32);

    // Boundaries, P=5: pulse 0 never high, pulse 6 always high.
    setup(1'b0, 0, 5, {16'd5, 16'd1, 16'd6, 16'd0}, 4'h0, 0);
    skip(2);
    for (int i = 0; i < 3; i++)
      push(1'b1, 6, {16'd5, 16'd1, 16'd6, 16'd0}, {16'd1, 16'd5, 16'd0, 16'd6});
    run(5, 6);

    // P=0: an update event every sclk.
    setup(1'b0, 0, 0, {16'hffff, 16'd2, 16'd1, 16'd0}, 4'h0, 0);
    skip(2);
    for (int i = 0; i < 4; i++)
      push(1'b1, 1, {16'd1, 16'd1, 16'd1, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd1});
    run(6, 1);

    // Shadowing: period changed to 4 at cnt=2 only takes effect after the next update.
    setup(1'b0, 0, 9, {16'd3, 16'd10, 16'd0, 16'd3}, 4'h0, 0);
    skip(1);
    for (int i = 0; i < 2; i++)
      push(1'b1, 10, {16'd3, 16'd10, 16'd0, 16'd3}, {16'd7, 16'd0, 16'd10, 16'd7});
    for (int i = 0; i < 3; i++)
      push(1'b1, 5, {16'd3, 16'd5, 16'd0, 16'd3}, {16'd2, 16'd0, 16'd5, 16'd2});
    en = 1'b1;
    repeat (22) @(negedge sclk);
    period = 16'd4;
    repeat (25) @(negedge sclk);
    en = 1'b0;

    // Dead-time 3, P=19: high time of act minus 3 on each output.
    setup(1'b0, 0, 19, {16'd20, 16'd0, 16'd5, 16'd10}, 4'h0, 3);
    skip(2);
    for (int i = 0; i < 3; i++)
      push(1'b1, 20, {16'd20, 16'd0, 16'd2, 16'd7}, {16'd0, 16'd20, 16'd12, 16'd7});
    run(5, 20);

    // Same with inverted polarity on all channels.
    setup(1'b0, 0, 19, {16'd20, 16'd0, 16'd5, 16'd10}, 4'hf, 3);
    skip(2);
    for (int i = 0; i < 3; i++)
      push(1'b1, 20, {16'd0, 16'd20, 16'd12, 16'd7}, {16'd20, 16'd0, 16'd2, 16'd7});
    run(5, 20);

    // Reset mid-pulse, then re-enable and time the first update event.
    setup(1'b0, 0, 9, {16'd3, 16'd10, 16'd0, 16'd3}, 4'h0, 0);
    skip(1);
    for (int i = 0; i < 2; i++)
      push(1'b1, 10, {16'd3, 16'd10, 16'd0, 16'd3}, {16'd7, 16'd0, 16'd10, 16'd7});
    en = 1'b1;
    repeat (33) @(negedge sclk);
    check("mid_pulse_ch0", int'(pwm_out[0]), 1);
    rst = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_pwm_out_n", int'(pwm_out_n), 0);
    check("async_rst_upd_evt", int'(upd_evt), 0);
    check("async_rst_cnt_val", int'(cnt_val), 0);
    en = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    repeat (3) @(negedge sclk);
    check("dis_pwm_out", int'(pwm_out), 0);
    check("dis_pwm_out_n", int'(pwm_out_n), 0);
    check("dis_cnt_val", int'(cnt_val), 0);
    skip(1);
    en  = 1'b1;
    lat = 0;
    while (upd_evt !== 1'b1 && lat < 50) begin
      @(negedge sclk);
      lat++;
    end
    check("first_upd_latency", lat, 10);
    en = 1'b0;

    repeat (5) @(negedge sclk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
